// File: rtl/mfsk_pkg.sv
// mfsk_pkg: shared constants and elaboration-time helpers for the M-ary
// phase-continuous FSK modulator.
//   - PRBS7 seed / tap positions (x^7 + x^6 + 1)
//   - sym_bits_ok():  legal range check for bits per symbol
//   - prbs7_next():   one shift of the PRBS7 generator
//   - sine_entry():   one signed entry of the full-cycle sine ROM
package mfsk_pkg;

    localparam int           PRBS_W      = 7;
    localparam logic [6:0]   PRBS_SEED   = 7'b1010101;
    localparam int           PRBS_TAP_HI = 6;   // x^7 term
    localparam int           PRBS_TAP_LO = 5;   // x^6 term

    localparam int           SYM_BITS_MIN = 1;
    localparam int           SYM_BITS_MAX = 4;

    localparam real          PI = 3.14159265358979323846;

    function automatic bit sym_bits_ok(input int bits);
        return (bits >= SYM_BITS_MIN) && (bits <= SYM_BITS_MAX);
    endfunction

    // Shift left, feedback into bit 0.
    function automatic logic [PRBS_W-1:0] prbs7_next(input logic [PRBS_W-1:0] s);
        return {s[PRBS_W-2:0], s[PRBS_TAP_HI] ^ s[PRBS_TAP_LO]};
    endfunction

    // round((2^(out_w-1)-1) * sin(2*pi*k / 2^lut_aw)), rounded to nearest.
    function automatic int sine_entry(input int k, input int out_w, input int lut_aw);
        real amp;
        real ang;
        real v;
        amp = real'((1 << (out_w - 1)) - 1);
        ang = 2.0 * PI * real'(k) / real'(1 << lut_aw);
        v   = amp * $sin(ang);
        return (v >= 0.0) ? $rtoi(v + 0.5) : $rtoi(v - 0.5);
    endfunction

endpackage

// File: rtl/mfsk_nco_mod_lut.sv
// mfsk_sine_lut: full-cycle signed sine ROM, combinational read.
//   i_addr  in  LUT_AW  table index (top bits of the NCO phase)
//   o_data  out OUT_W   two's complement sample, amplitude 2^(OUT_W-1)-1
module mfsk_sine_lut
    import mfsk_pkg::*;
#(
    parameter int OUT_W  = 8,
    parameter int LUT_AW = 6
)(
    input  logic [LUT_AW-1:0] i_addr,
    output logic [OUT_W-1:0]  o_data
);

    localparam int DEPTH = 2 ** LUT_AW;

    // NOTE: the ROM contents are constants computed at elaboration, so the
    // table is plain logic with no storage and therefore no reset.
    logic [OUT_W-1:0] w_rom [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        assign w_rom[k] = OUT_W'(sine_entry(k, OUT_W, LUT_AW));
    end

    assign o_data = w_rom[i_addr];

endmodule

// File: rtl/mfsk_nco_mod.sv
// mfsk_nco_mod: M-ary phase-continuous FSK modulator.
// A symbol-period counter picks a new symbol (internal PRBS7 or external
// valid/ready stream) at each boundary; the symbol sets the NCO frequency
// control word, and the NCO phase indexes a sine ROM.
//   clk, rst_n  clock / asynchronous active-low reset
//   en          global advance enable (everything holds when low)
//   src_sel     0 = PRBS7, 1 = external stream (used at boundaries only)
//   sym_div     clocks per symbol minus 1, reloaded at each boundary
//   base_fcw    FCW of symbol 0;  step_fcw  FCW increment per symbol value
//   ext_sym / ext_valid / ext_ready   external symbol handshake
//   sig_out     signed sample;  sig_valid  sample is fresh
//   sym_strobe  one-cycle pulse per boundary;  cur_sym  active symbol
//   underrun    one-cycle pulse when the external symbol was missing
module mfsk_nco_mod
    import mfsk_pkg::*;
#(
    parameter int OUT_W    = 8,
    parameter int PHASE_W  = 16,
    parameter int LUT_AW   = 6,
    parameter int SYM_BITS = 1,
    parameter int DIV_W    = 16
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                src_sel,
    input  logic [DIV_W-1:0]    sym_div,
    input  logic [PHASE_W-1:0]  base_fcw,
    input  logic [PHASE_W-1:0]  step_fcw,
    input  logic [SYM_BITS-1:0] ext_sym,
    input  logic                ext_valid,
    output logic                ext_ready,
    output logic [OUT_W-1:0]    sig_out,
    output logic                sig_valid,
    output logic                sym_strobe,
    output logic [SYM_BITS-1:0] cur_sym,
    output logic                underrun
);

    if (!sym_bits_ok(SYM_BITS)) begin : g_bad_sym_bits
        $error("mfsk_nco_mod: SYM_BITS must lie in 1..4");
    end

    logic [PHASE_W-1:0]  r_phase;
    logic [PHASE_W-1:0]  r_fcw;
    logic [DIV_W-1:0]    r_sym_cnt;
    logic [DIV_W-1:0]    r_divisor;
    logic [SYM_BITS-1:0] r_cur_sym;
    logic [PRBS_W-1:0]   r_lfsr;
    logic [OUT_W-1:0]    r_sig_out;
    logic                r_sig_valid;
    logic                r_sym_strobe;
    logic                r_underrun;

    logic                w_boundary;
    logic [PRBS_W-1:0]   w_lfsr_next;
    logic [SYM_BITS-1:0] w_new_sym;
    logic [PHASE_W-1:0]  w_new_fcw;
    logic [LUT_AW-1:0]   w_lut_addr;
    logic [OUT_W-1:0]    w_lut_data;

    // rst_n is folded in so ext_ready stays low throughout reset even when
    // en is high and sym_div is 0.
    assign w_boundary  = rst_n && en && (r_sym_cnt == r_divisor);
    assign ext_ready   = w_boundary && src_sel;
    assign w_lfsr_next = prbs7_next(r_lfsr);
    assign w_new_fcw   = base_fcw + PHASE_W'(w_new_sym) * step_fcw;
    assign w_lut_addr  = r_phase[PHASE_W-1 -: LUT_AW];

    // NOTE: every path starts from a default so the mux is pure
    // combinational logic and no latch is inferred.
    always_comb begin
        w_new_sym = r_cur_sym;
        if (!src_sel) begin
            w_new_sym = w_lfsr_next[SYM_BITS-1:0];
        end else if (ext_valid) begin
            w_new_sym = ext_sym;
        end
    end

    mfsk_sine_lut #(
        .OUT_W  (OUT_W),
        .LUT_AW (LUT_AW)
    ) u_lut (
        .i_addr (w_lut_addr),
        .o_data (w_lut_data)
    );

    // NOTE: state registers use non-blocking assignments so every register
    // sees the pre-edge value of the others (e.g. sig_out uses the old phase).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase      <= '0;
            r_fcw        <= base_fcw;
            r_sym_cnt    <= '0;
            r_divisor    <= sym_div;
            r_cur_sym    <= '0;
            r_lfsr       <= PRBS_SEED;
            r_sig_out    <= '0;
            r_sig_valid  <= 1'b0;
            r_sym_strobe <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_sig_valid  <= en;
            r_sym_strobe <= w_boundary;
            r_underrun   <= w_boundary && src_sel && !ext_valid;
            if (en) begin
                r_phase   <= r_phase + r_fcw;
                r_sig_out <= w_lut_data;
                if (w_boundary) begin
                    r_sym_cnt <= '0;
                    r_divisor <= sym_div;
                    r_cur_sym <= w_new_sym;
                    // Only the increment changes; phase itself never jumps.
                    r_fcw     <= w_new_fcw;
                    if (!src_sel) begin
                        r_lfsr <= w_lfsr_next;
                    end
                end else begin
                    r_sym_cnt <= r_sym_cnt + DIV_W'(1);
                end
            end
        end
    end

    assign sig_out    = r_sig_out;
    assign sig_valid  = r_sig_valid;
    assign sym_strobe = r_sym_strobe;
    assign cur_sym    = r_cur_sym;
    assign underrun   = r_underrun;

endmodule

// File: tb/tb_mfsk_nco_mod.sv
// Self-checking bench for mfsk_nco_mod (default parameters, SYM_BITS = 1).
module tb_mfsk_nco_mod;

    localparam int OUT_W    = 8;
    localparam int PHASE_W  = 16;
    localparam int LUT_AW   = 6;
    localparam int SYM_BITS = 1;
    localparam int DIV_W    = 16;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                en = 1'b0;
    logic                src_sel = 1'b0;
    logic [DIV_W-1:0]    sym_div = '0;
    logic [PHASE_W-1:0]  base_fcw = '0;
    logic [PHASE_W-1:0]  step_fcw = '0;
    logic [SYM_BITS-1:0] ext_sym = '0;
    logic                ext_valid = 1'b0;
    logic                ext_ready;
    logic [OUT_W-1:0]    sig_out;
    logic                sig_valid;
    logic                sym_strobe;
    logic [SYM_BITS-1:0] cur_sym;
    logic                underrun;

    mfsk_nco_mod #(
        .OUT_W(OUT_W), .PHASE_W(PHASE_W), .LUT_AW(LUT_AW),
        .SYM_BITS(SYM_BITS), .DIV_W(DIV_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .src_sel(src_sel),
        .sym_div(sym_div), .base_fcw(base_fcw), .step_fcw(step_fcw),
        .ext_sym(ext_sym), .ext_valid(ext_valid), .ext_ready(ext_ready),
        .sig_out(sig_out), .sig_valid(sig_valid), .sym_strobe(sym_strobe),
        .cur_sym(cur_sym), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_rdy, n_stb, n_und;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int prbs_state[127];          // PRBS7 state after i shifts from the seed
    int m_phase, m_fcw, m_pos, m_period, m_sym, m_nshift;
    int m_out;
    bit m_valid, m_strobe, m_under;

    function automatic int sine_ref(input int k);
        real v;
        v = 127.0 * $sin(2.0 * 3.141592653589793 * real'(k) / 64.0);
        return $rtoi($floor(v + 0.5));
    endfunction

    function automatic int sym_fcw(input int s);
        return (int'(base_fcw) + s * int'(step_fcw)) % 65536;
    endfunction

    task automatic build_prbs();
        int s, fb;
        s = 'h55;
        for (int i = 0; i < 127; i++) begin
            prbs_state[i] = s;
            fb = ((s >> 6) ^ (s >> 5)) & 1;
            s  = ((s << 1) | fb) & 127;
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_fcw = int'(base_fcw); m_pos = 0; m_period = int'(sym_div);
        m_sym = 0; m_nshift = 0; m_out = 0;
        m_valid = 0; m_strobe = 0; m_under = 0;
    endtask

    task automatic model_step();
        bit bnd;
        bnd      = en && (m_pos == m_period);
        m_valid  = en;
        m_strobe = bnd;
        m_under  = bnd && src_sel && !ext_valid;
        if (en) begin
            m_out   = sine_ref(m_phase / (1 << (PHASE_W - LUT_AW)));
            m_phase = (m_phase + m_fcw) % 65536;
            if (bnd) begin
                m_pos    = 0;
                m_period = int'(sym_div);
                if (src_sel) begin
                    if (ext_valid) m_sym = int'(ext_sym);
                end else begin
                    m_nshift++;
                    m_sym = prbs_state[m_nshift % 127] % (1 << SYM_BITS);
                end
                m_fcw = sym_fcw(m_sym);
            end else begin
                m_pos++;
            end
        end
    endtask

    // Called at posedge+1 with inputs already applied.
    task automatic tick();
        bit exp_rdy;
        exp_rdy = en && src_sel && (m_pos == m_period);
        @(negedge clk);
        check("ext_ready", int'(ext_ready), int'(exp_rdy));
        n_rdy += int'(ext_ready);
        @(posedge clk);
        model_step();
        #1;
        check("sig_out", int'($signed(sig_out)), m_out);
        check("sig_valid", int'(sig_valid), int'(m_valid));
        check("sym_strobe", int'(sym_strobe), int'(m_strobe));
        check("cur_sym", int'(cur_sym), m_sym);
        check("underrun", int'(underrun), int'(m_under));
        n_stb += int'(sym_strobe);
        n_und += int'(underrun);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        n_rdy = 0; n_stb = 0; n_und = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sig_out"}, int'(sig_out), 0);
        check({tag, "_sig_valid"}, int'(sig_valid), 0);
        check({tag, "_sym_strobe"}, int'(sym_strobe), 0);
        check({tag, "_cur_sym"}, int'(cur_sym), 0);
        check({tag, "_underrun"}, int'(underrun), 0);
        check({tag, "_ext_ready"}, int'(ext_ready), 0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit en, src, valid, sym;
        bit rdy, stb, cur, und, vld;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int tone_n[7];
        int tone_v[7];
        int prbs_first[7];

        build_prbs();

        // {en, src, valid, sym | ready, strobe, cur_sym, underrun, valid}
        vecs[0]  = '{1, 1, 1, 1,  0, 0, 0, 0, 1};
        vecs[1]  = '{1, 1, 1, 1,  0, 0, 0, 0, 1};
        vecs[2]  = '{1, 1, 1, 1,  1, 1, 1, 0, 1};
        vecs[3]  = '{0, 1, 1, 0,  0, 0, 1, 0, 0};
        vecs[4]  = '{1, 1, 0, 0,  0, 0, 1, 0, 1};
        vecs[5]  = '{1, 1, 0, 0,  0, 0, 1, 0, 1};
        vecs[6]  = '{1, 1, 0, 0,  1, 1, 1, 1, 1};
        vecs[7]  = '{1, 1, 1, 0,  0, 0, 1, 0, 1};
        vecs[8]  = '{1, 1, 1, 0,  0, 0, 1, 0, 1};
        vecs[9]  = '{1, 0, 1, 0,  0, 1, 1, 0, 1};  // first PRBS shift -> bit0 = 1
        vecs[10] = '{1, 0, 1, 0,  0, 0, 1, 0, 1};
        vecs[11] = '{1, 1, 1, 0,  0, 0, 1, 0, 1};
        vecs[12] = '{1, 1, 1, 0,  1, 1, 0, 0, 1};

        // ---- table: handshake / hold / underrun / source switch, sym_div = 2
        sym_div = 16'd2; base_fcw = 16'h0400; step_fcw = 16'h0400;
        src_sel = 1'b1; ext_valid = 1'b1;
        #1;
        check_all_zero("in_reset");
        apply_reset();
        for (int i = 0; i < 13; i++) begin
            en = vecs[i].en; src_sel = vecs[i].src;
            ext_valid = vecs[i].valid; ext_sym = vecs[i].sym;
            @(negedge clk);
            check($sformatf("vec%0d_ready", i), int'(ext_ready), int'(vecs[i].rdy));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_strobe", i), int'(sym_strobe), int'(vecs[i].stb));
            check($sformatf("vec%0d_cur_sym", i), int'(cur_sym), int'(vecs[i].cur));
            check($sformatf("vec%0d_underrun", i), int'(underrun), int'(vecs[i].und));
            check($sformatf("vec%0d_valid", i), int'(sig_valid), int'(vecs[i].vld));
        end

        // ---- single tone: symbol 0, fcw 0x0400, 64-cycle period
        en = 1'b0; src_sel = 1'b1; ext_valid = 1'b1; ext_sym = 1'b0;
        base_fcw = 16'h0400; step_fcw = 16'h0400; sym_div = 16'd1000;
        apply_reset();
        en = 1'b1;
        tone_n = '{1, 2, 3, 9, 17, 49, 65};
        tone_v = '{0, 12, 25, 90, 127, -127, 0};
        for (int n = 1; n <= 65; n++) begin
            tick();
            for (int j = 0; j < 7; j++)
                if (n == tone_n[j])
                    check($sformatf("tone_sample%0d", n), int'($signed(sig_out)), tone_v[j]);
        end

        // ---- phase continuity: alternate symbols 1/0 every 16 cycles
        en = 1'b0; ext_sym = 1'b1; sym_div = 16'd15;
        apply_reset();
        en = 1'b1;
        for (int n = 1; n <= 128; n++) begin
            tick();
            // index 16 -> 18 -> 20 across the first boundary, no jump
            if (n == 17) check("cont_s17", int'($signed(sig_out)), 127);
            if (n == 18) check("cont_s18", int'($signed(sig_out)), 125);
            if (n == 19) check("cont_s19", int'($signed(sig_out)), 117);
            if (m_strobe) ext_sym = ~ext_sym;
        end

        // ---- handshake / underrun: valid missing at the second boundary only
        en = 1'b0; ext_sym = 1'b1; ext_valid = 1'b1; sym_div = 16'd15;
        apply_reset();
        en = 1'b1;
        for (int n = 1; n <= 64; n++) begin
            if (n == 30) begin ext_valid = 1'b0; ext_sym = 1'b0; end
            if (n == 35) ext_valid = 1'b1;
            tick();
            if (n == 16) check("hs_cur_after_b1", int'(cur_sym), 1);
            if (n == 32) check("hs_cur_held", int'(cur_sym), 1);
            if (n == 48) check("hs_cur_after_b3", int'(cur_sym), 0);
        end
        check("hs_ready_count", n_rdy, 4);
        check("hs_underrun_count", n_und, 1);

        // ---- PRBS7, one symbol per cycle, past a full period
        en = 1'b0; src_sel = 1'b0; sym_div = 16'd0;
        apply_reset();
        en = 1'b1;
        prbs_first = '{1, 1, 1, 1, 1, 1, 0};
        for (int n = 1; n <= 260; n++) begin
            tick();
            if (n <= 7) check($sformatf("prbs_sym%0d", n), int'(cur_sym), prbs_first[n-1]);
        end

        // ---- FCW wrap: 0xFFFF + 1 = 0 freezes the phase; strobe every cycle
        en = 1'b0; src_sel = 1'b1; ext_valid = 1'b1; ext_sym = 1'b1;
        base_fcw = 16'hFFFF; step_fcw = 16'h0001; sym_div = 16'd0;
        apply_reset();
        en = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (n >= 2) check($sformatf("wrap_s%0d", n), int'($signed(sig_out)), -12);
        end
        check("wrap_strobe_count", n_stb, 10);

        // ---- randomized traffic against the model
        en = 1'b0; sym_div = 16'd3;
        base_fcw = 16'($urandom); step_fcw = 16'($urandom);
        apply_reset();
        for (int n = 0; n < 1500; n++) begin
            en        = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 19) == 0) src_sel = ~src_sel;
            ext_valid = ($urandom_range(0, 9) < 7);
            ext_sym   = SYM_BITS'($urandom);
            sym_div   = DIV_W'($urandom_range(0, 4));
            if ((n % 200) == 199) begin
                base_fcw = 16'($urandom);
                step_fcw = 16'($urandom);
            end
            tick();
        end

        // ---- reset mid-run clears outputs at once, then idle with en low
        en = 1'b1; src_sel = 1'b1; ext_valid = 1'b1; sym_div = 16'd0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        check("rst_ready_low", int'(ext_ready), 0);
        en = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        n_rdy = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            check("idle_sig_out", int'(sig_out), 0);
        end
        check("idle_ready_count", n_rdy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mfsk_nco_mod.md
Name: mfsk_nco_mod

Overview:
Parametrised M-ary, phase-continuous FSK modulator. It is the successor of the fixed 2-tone, table-stepped FSK block. A phase accumulator (NCO) is driven by a per-symbol frequency control word, so tone switches never cause a phase jump. Symbols come from an internal PRBS7 generator or from an external valid/ready stream. The block feeds the DAC/scope path of the modem chain.

Parameters:
OUT_W, 8, signed sample width; LUT amplitude is 2^(OUT_W-1)-1
PHASE_W, 16, phase accumulator and FCW width
LUT_AW, 6, log2 of full-cycle sine table depth; address = phase[PHASE_W-1 -: LUT_AW]
SYM_BITS, 1, bits per symbol; M = 2^SYM_BITS tones; legal range 1..4
DIV_W, 16, symbol-period counter width

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  global advance enable
src_sel  in  1  0 = internal PRBS7, 1 = external stream
sym_div  in  DIV_W  clocks per symbol minus 1; sampled at each boundary
base_fcw  in  PHASE_W  FCW of symbol 0
step_fcw  in  PHASE_W  FCW increment per symbol value
ext_sym  in  SYM_BITS  external symbol
ext_valid  in  1  external symbol available
ext_ready  out  1  symbol accepted this cycle
sig_out  out  OUT_W  signed modulated sample
sig_valid  out  1  sig_out is fresh
sym_strobe  out  1  one-cycle pulse when a new symbol takes effect
cur_sym  out  SYM_BITS  symbol currently modulated
underrun  out  1  one-cycle pulse: external symbol missing at a boundary

Behaviour:
- Reset (async, active-low):
  - phase=0, fcw=base_fcw (sampled continuously while in reset), sym_cnt=0, cur_sym=0, lfsr=7'b1010101, divisor=sym_div.
  - All outputs 0.
- en low: phase, counter, LFSR and all registers hold; sig_valid=0; ext_ready=0; no pulses.
- Symbol counter: counts 0..divisor with en high. Boundary = (en && sym_cnt==divisor). At a boundary:
  - counter returns to 0;
  - divisor reloads from sym_div;
  - next symbol is selected.
  - sym_div=0 gives a boundary every enabled cycle.
- Symbol selection at boundary:
  - Internal: lfsr shifts once, polynomial x^7+x^6+1, feedback lfsr[6]^lfsr[5] into bit 0. New symbol = low SYM_BITS bits of the post-shift state.
  - External: ext_ready = boundary && src_sel (combinational; never high otherwise). If ext_valid is high, ext_sym is taken. Otherwise cur_sym holds and underrun pulses. LFSR does not advance in external mode.
- On boundary, registered in the same edge:
  - cur_sym <= new symbol;
  - fcw <= base_fcw + new_sym*step_fcw, truncated mod 2^PHASE_W;
  - sym_strobe <= 1 for one cycle.
  - The new fcw affects phase starting the following enabled edge.
- NCO: each enabled edge, phase <= phase + fcw (mod 2^PHASE_W). Wrap-around is silent.
- Output: each enabled edge, sig_out <= LUT[phase[PHASE_W-1 -: LUT_AW]] using the pre-update phase. So sig_out lags the phase register by one cycle. sig_valid <= en.
- LUT: entry k = round((2^(OUT_W-1)-1)*sin(2*pi*k/2^LUT_AW)), two's complement. For 64x8: k=8 -> 90, k=16 -> 127, k=48 -> -127.
- src_sel change takes effect at the next boundary only.
- Reset mid-symbol aborts immediately; the first symbol after reset is 0 until the first boundary.

Decomposition:
- Package mfsk_pkg holds:
  - PRBS7 seed and tap constants;
  - SYM_BITS legal-range check function;
  - sine-table generator function, elaboration-time real math producing the ROM init.
- One sub-module: mfsk_sine_lut (parametrised by OUT_W, LUT_AW; combinational ROM read). The top holds counter, symbol select, FCW and NCO registers.

Test Plan:
- Reset/idle: rst_n low mid-run -> all outputs 0 immediately. After release with en=0 for 10 cycles -> outputs stay 0, ext_ready never high.
- Single tone: src_sel=1, ext_valid=1, ext_sym=0, base_fcw=0x0400, sym_div=1000, en=1 -> sig_out follows 0,12,25,...; sig_out=127 at 17th valid sample; period 64 cycles.
- Phase continuity: base=0x0400, step=0x0400, sym_div=15, ext_sym alternating 0/1 -> at each sym_strobe the LUT index continues from the current phase (no jump). Index increments by 1 per cycle for symbol 0 and by 2 for symbol 1.
- Handshake/underrun: src_sel=1, deassert ext_valid for one boundary -> ext_ready high exactly one cycle per 16, underrun pulses once, cur_sym unchanged.
- PRBS: src_sel=0, SYM_BITS=1, sym_div=0 -> cur_sym sequence matches the x^7+x^6+1 reference from seed 1010101 and repeats after 127 symbols.
- Wrap/sym_div=0: base=0xFFFF, step=0x0001, SYM_BITS=2 -> symbol 1 gives fcw=0x0000 (phase frozen). sym_strobe is high every enabled cycle.
